tone_sequencer: RTL and testbench

- Sequences the audio output pin from a small programmable note table.
- Each entry is a note: a square-wave half-period plus a duration. The block plays entries in order and drives `aud` directly.
- It sits between the host/control logic, which loads the table and issues start/stop, and the board audio pin.
- It replaces free-running tone generation with a controlled, restartable melody player.

---
 rtl/tone_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Melody player: walks a small {half-period, duration} note table and drives a
// registered square wave on aud, with loop, stop and gapless note chaining.
module tone_sequencer #(
   parameter int NOTES    = 8,
   parameter int PERIOD_W = 16,
   parameter int DUR_W    = 16,
   parameter int TICK_DIV = 1000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(NOTES)-1:0] wr_addr,
   input  logic [PERIOD_W-1:0]      wr_period,
   input  logic [DUR_W-1:0]         wr_dur,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     loop,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(NOTES)-1:0] idx,
   output logic                     aud
);

   localparam int IDX_W  = $clog2(NOTES);
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NOTES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [PERIOD_W-1:0] period_mem [NOTES];
   logic [DUR_W-1:0]    dur_mem    [NOTES];

   state_t              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [PERIOD_W-1:0] period_q;
   logic [DUR_W-1:0]    dur_q;
   logic [PERIOD_W-1:0] hp_q;
   logic [TICK_W-1:0]   tick_q;
   logic [DUR_W-1:0]    cnt_q;
   logic                aud_q;
   logic                busy_q;
   logic                done_q;

   logic [PERIOD_W-1:0] fetch_period_d;
   logic [DUR_W-1:0]    fetch_dur_d;
   logic                tick_wrap_d;
   logic                note_end_d;
   logic                hp_wrap_d;
   logic                tone_d;

   // Table is only writable while idle so a running melody never changes under us.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_q) begin
         period_mem[wr_addr] <= wr_period;
         dur_mem[wr_addr]    <= wr_dur;
      end
   end

   always_comb begin
      fetch_period_d = period_mem[idx_q];
      fetch_dur_d    = dur_mem[idx_q];
      tick_wrap_d    = (tick_q == TICK_LAST);
      note_end_d     = tick_wrap_d && ((cnt_q + DUR_W'(1)) == dur_q);
      hp_wrap_d      = (hp_q == (period_q - PERIOD_W'(1)));
      tone_d         = (period_q != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         period_q <= '0;
         dur_q    <= '0;
         hp_q     <= '0;
         tick_q   <= '0;
         cnt_q    <= '0;
         aud_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stop) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            aud_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  aud_q <= 1'b0;
                  if (start) begin
                     state_q <= S_FETCH;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               S_FETCH: begin
                  period_q <= fetch_period_d;
                  dur_q    <= fetch_dur_d;
                  aud_q    <= 1'b0;
                  if (fetch_dur_d == '0) begin
                     // A marker at entry 0 always ends, so an empty table cannot spin.
                     if ((idx_q != '0) && loop) begin
                        idx_q <= '0;
                     end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     state_q <= S_PLAY;
                     hp_q    <= '0;
                     tick_q  <= '0;
                     cnt_q   <= '0;
                  end
               end
               S_PLAY: begin
                  tick_q <= tick_wrap_d ? '0 : tick_q + TICK_W'(1);
                  if (tick_wrap_d) begin
                     cnt_q <= cnt_q + DUR_W'(1);
                  end
                  if (tone_d) begin
                     hp_q <= hp_wrap_d ? '0 : hp_q + PERIOD_W'(1);
                     if (hp_wrap_d) begin
                        aud_q <= ~aud_q;
                     end
                  end
                  if (note_end_d) begin
                     aud_q <= 1'b0;
                     if (idx_q != LAST_IDX) begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_FETCH;
                     end else if (loop) begin
                        idx_q   <= '0;
                        state_q <= S_FETCH;
                     end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  aud_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
                  aud_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign idx  = idx_q;
   assign aud  = aud_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: hand-derived vector table, corner-case
// sequences, and randomized tables checked against a note-level playback model.
module tb_tone_sequencer;

   localparam int NOTES = 8;
   localparam int PW    = 16;
   localparam int DW    = 16;
   localparam int TD    = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_period = '0;
   logic [15:0] wr_dur = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic        busy;
   logic        done;
   logic [2:0]  idx;
   logic        aud;

   tone_sequencer #(
      .NOTES(NOTES), .PERIOD_W(PW), .DUR_W(DW), .TICK_DIV(TD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_period(wr_period), .wr_dur(wr_dur), .start(start), .stop(stop),
      .loop(loop), .busy(busy), .done(done), .idx(idx), .aud(aud)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected table contents as seen by the model
   int m_per [NOTES];
   int m_dur [NOTES];

   // Observation record: {aud, busy, done, idx}
   typedef logic [5:0] obs_t;
   obs_t exp_q [$];

   typedef struct {
      logic [7:0][15:0] per;
      logic [7:0][15:0] dur;
      bit               lp;
      int               exp_done_cyc;
      int               exp_idx;
      int               exp_rises;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int p, input int d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_period = 16'(p); wr_dur = 16'(d);
      tick();
      wr_en = 1'b0;
      m_per[a] = p;
      m_dur[a] = d;
   endtask

   function automatic obs_t mk(input bit a, input bit b, input bit d, input int i);
      return {a, b, d, 3'(i)};
   endfunction

   // Playback model: each note is one fetch cycle plus dur*TD play cycles whose
   // aud value is the parity of (cycles since note start / period).
   task automatic build(input bit lp, input int maxc);
      int i;
      bit fin;
      i = 0;
      fin = 0;
      exp_q.delete();
      while (!fin && exp_q.size() < maxc) begin
         exp_q.push_back(mk(0, 1, 0, i));
         if (m_dur[i] == 0) begin
            if (i == 0 || !lp) fin = 1;
            else i = 0;
         end else begin
            for (int j = 0; j < m_dur[i] * TD; j++)
               exp_q.push_back(mk(m_per[i] != 0 && ((j / m_per[i]) % 2 == 1), 1, 0, i));
            if (i < NOTES - 1) i++;
            else if (lp) i = 0;
            else fin = 1;
         end
      end
      if (fin) begin
         exp_q.push_back(mk(0, 0, 1, i));
         for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 0, i));
      end
   endtask

   task automatic run_to_done(output int cyc, output int ridx, output int rises);
      logic prev;
      cyc = 0;
      rises = 0;
      prev = aud;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
         if (aud && !prev) rises++;
         prev = aud;
      end
      ridx = int'(idx);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_vectors();
      int cyc, ridx, rises, extra;
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < NOTES; i++) wr(i, int'(vecs[v].per[i]), int'(vecs[v].dur[i]));
         loop = vecs[v].lp;
         do_start();
         check($sformatf("vec%0d_busy_after_start", v), busy, 1);
         run_to_done(cyc, ridx, rises);
         check($sformatf("vec%0d_done_cycle", v), cyc, vecs[v].exp_done_cyc);
         check($sformatf("vec%0d_idx_at_done", v), ridx, vecs[v].exp_idx);
         check($sformatf("vec%0d_aud_rises", v), rises, vecs[v].exp_rises);
         extra = 0;
         for (int k = 0; k < 4; k++) begin
            tick();
            if (done || busy || aud) extra++;
         end
         check($sformatf("vec%0d_quiet_after_done", v), extra, 0);
         $display("vector %0d: done after %0d cycles, idx %0d, %0d aud rises", v, cyc, ridx, rises);
         loop = 1'b0;
      end
   endtask

   task automatic test_loop_wrap();
      logic [2:0] prev;
      int wrapped, dpulses, seen, c;
      for (int i = 0; i < NOTES; i++) wr(i, 1, 1);
      loop = 1'b1;
      do_start();
      wrapped = 0; dpulses = 0; prev = idx; c = 0;
      while (!wrapped && c < 150) begin
         tick(); c++;
         if (done) dpulses++;
         if (prev == 3'd7 && idx == 3'd0) wrapped = 1;
         prev = idx;
      end
      check("loop_wrapped_to_0", wrapped, 1);
      check("loop_no_done_on_wrap", dpulses, 0);
      loop = 1'b0;
      seen = 0; c = 0;
      while (!seen && c < 150) begin
         tick(); c++;
         if (done) seen = 1;
      end
      check("loop_done_after_unloop", seen, 1);
      check("loop_done_idx", idx, 7);
      $display("loop wrap: wrapped=%0d, done after unloop=%0d at idx %0d", wrapped, seen, idx);
      tick();
   endtask

   task automatic test_stop();
      int bad;
      wr(0, 3, 5); wr(1, 0, 0);
      do_start();
      for (int k = 0; k < 5; k++) tick();
      check("stop_pre_aud_high", aud, 1);
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_aud", aud, 0);
      check("stop_idx", idx, 0);
      check("stop_done", done, 0);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done || busy || aud) bad++;
      end
      check("stop_stays_idle", bad, 0);
      $display("stop mid-note: busy=%0d aud=%0d idx=%0d", busy, aud, idx);
   endtask

   task automatic test_write_busy();
      int cyc, ridx, rises;
      wr(0, 2, 2); wr(1, 0, 0);
      do_start();
      tick();
      wr_en = 1'b1; wr_addr = 3'd1; wr_period = 16'd7; wr_dur = 16'd5;
      tick();
      wr_addr = 3'd0; wr_period = 16'd1; wr_dur = 16'd0;
      tick();
      wr_en = 1'b0;
      cyc = 3;
      while (!done && cyc < 200) begin tick(); cyc++; end
      check("wrbusy_done_cycle", cyc, 10);
      tick();
      do_start();
      run_to_done(cyc, ridx, rises);
      check("wrbusy_replay_cycle", cyc, 10);
      check("wrbusy_replay_rises", rises, 2);
      $display("write while busy: replay done after %0d cycles, %0d rises", cyc, rises);
      tick();
   endtask

   task automatic test_async_reset();
      int c;
      wr(0, 2, 3); wr(1, 0, 0);
      do_start();
      c = 0;
      while (!aud && c < 50) begin tick(); c++; end
      check("arst_aud_high_before", aud, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_aud", aud, 0);
      check("arst_busy", busy, 0);
      check("arst_idx", idx, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_done_after", done, 0);
      $display("async reset mid-play: aud=%0d busy=%0d", aud, busy);
   endtask

   task automatic test_random(input int runs);
      bit lp;
      int mism;
      for (int r = 0; r < runs; r++) begin
         for (int i = 0; i < NOTES; i++)
            wr(i, int'($urandom_range(0, 5)),
               ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3)));
         lp = 1'($urandom_range(0, 1));
         loop = lp;
         build(lp, 80);
         do_start();
         mism = n_bad;
         for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) tick();
            check($sformatf("rand%0d_cyc%0d", r, k), {aud, busy, done, idx}, exp_q[k]);
         end
         if (exp_q[exp_q.size() - 1][4]) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check($sformatf("rand%0d_stop", r), {aud, busy, done, idx}, 6'd0);
         end
         loop = 1'b0;
         $display("random run %0d: loop=%0d, %0d cycles, %0d new errors", r, lp, exp_q.size(), n_bad - mism);
         tick();
      end
   endtask

   initial begin
      vecs[0] = '{per: '0, dur: '0, lp: 1'b0, exp_done_cyc: 10, exp_idx: 1, exp_rises: 1};
      vecs[0].per[0] = 16'd3; vecs[0].dur[0] = 16'd2;
      vecs[1] = '{per: '0, dur: '0, lp: 1'b0, exp_done_cyc: 20, exp_idx: 3, exp_rises: 1};
      vecs[1].per[0] = 16'd2; vecs[1].dur[0] = 16'd1;
      vecs[1].per[1] = 16'd0; vecs[1].dur[1] = 16'd2;
      vecs[1].per[2] = 16'd5; vecs[1].dur[2] = 16'd1;
      vecs[2] = '{per: '0, dur: '0, lp: 1'b1, exp_done_cyc: 1, exp_idx: 0, exp_rises: 0};
      vecs[3] = '{per: '0, dur: '0, lp: 1'b0, exp_done_cyc: 40, exp_idx: 7, exp_rises: 16};
      for (int i = 0; i < NOTES; i++) begin
         vecs[3].per[i] = 16'd1; vecs[3].dur[i] = 16'd1;
      end
      vecs[4] = '{per: '0, dur: '0, lp: 1'b0, exp_done_cyc: 11, exp_idx: 2, exp_rises: 0};
      vecs[4].per[0] = 16'd4; vecs[4].dur[0] = 16'd1;
      vecs[4].per[1] = 16'd0; vecs[4].dur[1] = 16'd1;
      vecs[5] = '{per: '0, dur: '0, lp: 1'b0, exp_done_cyc: 14, exp_idx: 1, exp_rises: 6};
      vecs[5].per[0] = 16'd1; vecs[5].dur[0] = 16'd3;

      rst_n = 1'b0;
      tick(); tick();
      check("reset_aud", aud, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_idx", idx, 0);
      rst_n = 1'b1;
      tick();

      run_vectors();
      test_loop_wrap();
      test_stop();
      test_write_busy();
      test_async_reset();
      test_random(25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
